// File: rtl/poly_series_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : poly_series_pkg
//  Description : Shared definitions for the geometric-series accelerator:
//                register byte offsets, STATUS bit positions, FSM state
//                encoding and the TERMS reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
package poly_series_pkg;

   // Register byte offsets from the device base address
   localparam logic [31:0] OFF_OP     = 32'h0000_0000;
   localparam logic [31:0] OFF_ANS    = 32'h0000_0004;
   localparam logic [31:0] OFF_CTRL   = 32'h0000_0008;
   localparam logic [31:0] OFF_TERMS  = 32'h0000_000C;
   localparam logic [31:0] OFF_STATUS = 32'h0000_0010;

   // STATUS register bit positions
   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_OVF  = 2;

   // Term count loaded into TERMS at reset (matches the legacy 5-term device)
   localparam int TERMS_RST = 5;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/series_term_unit.sv
`default_nettype none
// ============================================================================
//  Module      : series_term_unit
//  Description : Combinational step of the series: next power term t*x and
//                next partial sum acc+t, both wrapped to DATA_W bits, with
//                flags for the discarded high product half and the add carry.
//  Ports       : i_term        - current power term t
//                i_x           - series base x
//                i_acc         - current partial sum
//                o_term_next   - low DATA_W bits of t*x
//                o_term_ovf    - high DATA_W bits of t*x are nonzero
//                o_acc_next    - acc + t, wrapped
//                o_acc_carry   - carry out of acc + t
//  Revision    : 1.0 - initial release
// ============================================================================
module series_term_unit #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] i_term,
   input  logic [DATA_W-1:0] i_x,
   input  logic [DATA_W-1:0] i_acc,
   output logic [DATA_W-1:0] o_term_next,
   output logic              o_term_ovf,
   output logic [DATA_W-1:0] o_acc_next,
   output logic              o_acc_carry
);

   logic [2*DATA_W-1:0] w_prod;
   logic [DATA_W:0]     w_sum;

   // Operands are widened explicitly so the full double-width product is kept
   assign w_prod = {{DATA_W{1'b0}}, i_term} * {{DATA_W{1'b0}}, i_x};
   assign w_sum  = {1'b0, i_acc} + {1'b0, i_term};

   assign o_term_next = w_prod[DATA_W-1:0];
   assign o_term_ovf  = |w_prod[2*DATA_W-1:DATA_W];
   assign o_acc_next  = w_sum[DATA_W-1:0];
   assign o_acc_carry = w_sum[DATA_W];

endmodule
`default_nettype wire

// File: rtl/poly_series_device.sv
`default_nettype none
// ============================================================================
//  Module      : poly_series_device
//  Description : Memory-mapped accelerator evaluating
//                S = x^0 + x^1 + ... + x^(N-1) mod 2^DATA_W, one term per
//                clock, with run-time term count, status, abort and a
//                register file that is write-protected while busy.
//  Ports       : clk               - system clock, rising edge
//                reset             - asynchronous active-low reset
//                MemRead           - bus read strobe
//                MemWrite          - bus write strobe
//                MemBus_Address    - byte address (exact 32-bit decode)
//                MemBus_Write_Data - write data
//                Device_Read_Data  - combinational read data (0 if no hit)
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_series_device
   import poly_series_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          MAX_TERMS = 16,
   parameter int          CNT_W     = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [31:0]       MemBus_Address,
   input  logic [DATA_W-1:0] MemBus_Write_Data,
   output logic [DATA_W-1:0] Device_Read_Data
);

   localparam logic [31:0] c_addr_op     = BASE_ADDR + OFF_OP;
   localparam logic [31:0] c_addr_ans    = BASE_ADDR + OFF_ANS;
   localparam logic [31:0] c_addr_ctrl   = BASE_ADDR + OFF_CTRL;
   localparam logic [31:0] c_addr_terms  = BASE_ADDR + OFF_TERMS;
   localparam logic [31:0] c_addr_status = BASE_ADDR + OFF_STATUS;
   localparam logic [CNT_W:0]   c_max_terms = (CNT_W+1)'(MAX_TERMS);
   localparam logic [CNT_W:0]   c_terms_rst = (CNT_W+1)'(TERMS_RST);
   localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] op_q, op_d;
   logic [CNT_W:0]    terms_q, terms_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] t_q, t_d;
   logic              t_ovf_q, t_ovf_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  n_eff_q, n_eff_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;

   logic              w_wr_op;
   logic              w_wr_ctrl;
   logic              w_wr_terms;
   logic              w_wdata_nz;
   logic [CNT_W-1:0]  w_n_clamp;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic [DATA_W-1:0] w_term_next;
   logic              w_term_ovf;
   logic [DATA_W-1:0] w_acc_next;
   logic              w_acc_carry;
   logic              w_busy;
   logic [DATA_W-1:0] w_status;

   // ------------------------------------------------------------------
   // Write decode
   // ------------------------------------------------------------------
   assign w_wr_op    = MemWrite && (MemBus_Address == c_addr_op);
   assign w_wr_ctrl  = MemWrite && (MemBus_Address == c_addr_ctrl);
   assign w_wr_terms = MemWrite && (MemBus_Address == c_addr_terms);
   assign w_wdata_nz = (MemBus_Write_Data != '0);

   // MAX_TERMS < 2^CNT_W, so the clamped count always fits CNT_W bits
   assign w_n_clamp = (terms_q > c_max_terms) ? c_max_terms[CNT_W-1:0]
                                              : terms_q[CNT_W-1:0];
   assign w_cnt_inc = cnt_q + c_cnt_one;
   assign w_busy    = (state_q == RUN);

   // x is taken live from OP; OP cannot change while a run is in progress
   series_term_unit #(
      .DATA_W (DATA_W)
   ) u_term (
      .i_term      (t_q),
      .i_x         (op_q),
      .i_acc       (acc_q),
      .o_term_next (w_term_next),
      .o_term_ovf  (w_term_ovf),
      .o_acc_next  (w_acc_next),
      .o_acc_carry (w_acc_carry)
   );

   // ------------------------------------------------------------------
   // Next-state / register update logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      terms_d = terms_q;
      acc_d   = acc_q;
      t_d     = t_q;
      t_ovf_d = t_ovf_q;
      cnt_d   = cnt_q;
      n_eff_d = n_eff_q;
      done_d  = done_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (w_wr_op) begin
               op_d = MemBus_Write_Data;
            end
            if (w_wr_terms) begin
               terms_d = MemBus_Write_Data[CNT_W:0];
            end
            if (w_wr_ctrl && w_wdata_nz) begin
               n_eff_d = w_n_clamp;
               acc_d   = '0;
               t_d     = {{(DATA_W-1){1'b0}}, 1'b1};
               t_ovf_d = 1'b0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               // An empty series completes at the start edge itself
               if (w_n_clamp == '0) begin
                  done_d = 1'b1;
               end else begin
                  done_d  = 1'b0;
                  state_d = RUN;
               end
            end
         end

         RUN: begin
            // Abort beats the accumulate step on the same edge
            if (w_wr_ctrl && !w_wdata_nz) begin
               state_d = IDLE;
               done_d  = 1'b0;
            end else begin
               acc_d   = w_acc_next;
               t_d     = w_term_next;
               t_ovf_d = t_ovf_q | w_term_ovf;
               // t_ovf_q flags a term that was already wrapped before this add
               ovf_d   = ovf_q | t_ovf_q | w_acc_carry;
               cnt_d   = w_cnt_inc;
               if (w_cnt_inc == n_eff_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         terms_q <= c_terms_rst;
         acc_q   <= '0;
         t_q     <= '0;
         t_ovf_q <= 1'b0;
         cnt_q   <= '0;
         n_eff_q <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         terms_q <= terms_d;
         acc_q   <= acc_d;
         t_q     <= t_d;
         t_ovf_q <= t_ovf_d;
         cnt_q   <= cnt_d;
         n_eff_q <= n_eff_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   // ------------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------------
   always_comb begin
      w_status          = '0;
      w_status[ST_BUSY] = w_busy;
      w_status[ST_DONE] = done_q;
      w_status[ST_OVF]  = ovf_q;
   end

   always_comb begin
      Device_Read_Data = '0;
      if (MemRead) begin
         if (MemBus_Address == c_addr_op) begin
            Device_Read_Data = op_q;
         end else if (MemBus_Address == c_addr_ans) begin
            Device_Read_Data = acc_q;
         end else if (MemBus_Address == c_addr_terms) begin
            Device_Read_Data = DATA_W'(terms_q);
         end else if (MemBus_Address == c_addr_status) begin
            Device_Read_Data = w_status;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_poly_series_device.sv
`default_nettype none
// ============================================================================
//  Module      : tb_poly_series_device
//  Description : Scoreboard bench for poly_series_device. Every cycle the
//                driver queues the read value expected from a behavioural
//                register/series model; a monitor pops and compares on the
//                falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_series_device;

   localparam logic [31:0] BASE     = 32'h4000_0000;
   localparam logic [31:0] A_OP     = BASE + 32'h00;
   localparam logic [31:0] A_ANS    = BASE + 32'h04;
   localparam logic [31:0] A_CTRL   = BASE + 32'h08;
   localparam logic [31:0] A_TERMS  = BASE + 32'h0C;
   localparam logic [31:0] A_STATUS = BASE + 32'h10;
   localparam logic [31:0] A_NONE   = BASE + 32'h14;

   logic        clk;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] MemBus_Address;
   logic [31:0] MemBus_Write_Data;
   logic [31:0] Device_Read_Data;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] val;
      string       name;
   } exp_t;
   exp_t exp_q[$];

   // Behavioural model state
   logic [31:0] m_op;
   logic [5:0]  m_terms;
   logic [31:0] m_x;
   int          m_k;
   int          m_n;
   bit          m_busy;
   bit          m_done;

   poly_series_device #(
      .DATA_W    (32),
      .BASE_ADDR (BASE),
      .MAX_TERMS (16),
      .CNT_W     (5)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .MemRead           (MemRead),
      .MemWrite          (MemWrite),
      .MemBus_Address    (MemBus_Address),
      .MemBus_Write_Data (MemBus_Write_Data),
      .Device_Read_Data  (Device_Read_Data)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   // Sum of the first k powers of x, wrapped to 32 bits
   function automatic logic [31:0] geo_ans(logic [31:0] x, int k);
      logic [31:0] s;
      logic [31:0] p;
      s = 32'd0;
      p = 32'd1;
      for (int i = 0; i < k; i++) begin
         s = s + p;
         p = p * x;
      end
      return s;
   endfunction

   // True (unwrapped) sum of the first k powers reaches 2^32
   function automatic bit geo_ovf(logic [31:0] x, int k);
      longint unsigned s;
      longint unsigned p;
      s = 0;
      p = 1;
      for (int i = 0; i < k; i++) begin
         s = s + p;
         if (s >= 64'h1_0000_0000) return 1'b1;
         p = p * {32'd0, x};
         if (p > 64'h1_0000_0000) p = 64'h1_0000_0000;
      end
      return 1'b0;
   endfunction

   function automatic logic [31:0] exp_read(logic [31:0] a);
      if (a == A_OP)     return m_op;
      if (a == A_ANS)    return geo_ans(m_x, m_k);
      if (a == A_TERMS)  return {26'd0, m_terms};
      if (a == A_STATUS) return {29'd0, geo_ovf(m_x, m_k), m_done, m_busy};
      return 32'd0;
   endfunction

   task automatic model_reset();
      m_op    = 32'd0;
      m_terms = 6'd5;
      m_x     = 32'd0;
      m_k     = 0;
      m_n     = 0;
      m_busy  = 1'b0;
      m_done  = 1'b0;
   endtask

   task automatic model_edge(bit we, logic [31:0] a, logic [31:0] d);
      bit wctrl;
      wctrl = we && (a == A_CTRL);
      if (m_busy) begin
         if (wctrl && d == 32'd0) begin
            m_busy = 1'b0;
            m_done = 1'b0;
         end else begin
            m_k++;
            if (m_k == m_n) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end
      end else begin
         if (we && a == A_OP)    m_op = d;
         if (we && a == A_TERMS) m_terms = d[5:0];
         if (wctrl && d != 32'd0) begin
            m_n    = (int'(m_terms) > 16) ? 16 : int'(m_terms);
            m_x    = m_op;
            m_k    = 0;
            m_busy = (m_n != 0);
            m_done = (m_n == 0);
         end
      end
   endtask

   // One bus cycle: inputs applied after a rising edge, checked on the
   // following falling edge, committed on the next rising edge.
   task automatic cycle(bit we, logic [31:0] wa, logic [31:0] wd,
                        bit re, logic [31:0] ra, bit rst_low,
                        bit use_k, logic [31:0] kval);
      exp_t e;
      reset             = rst_low ? 1'b0 : 1'b1;
      if (rst_low) model_reset();
      MemWrite          = we;
      MemBus_Address    = re ? ra : wa;
      MemBus_Write_Data = wd;
      MemRead           = re;
      if (we && re && (ra != wa)) begin
         // single address bus: the read address takes the bus
         MemWrite = 1'b0;
         we       = 1'b0;
      end
      e.val  = use_k ? kval : (re ? exp_read(ra) : 32'd0);
      e.name = $sformatf("rd%0d@%h", re, ra);
      exp_q.push_back(e);
      @(posedge clk);
      if (!rst_low) model_edge(we, wa, wd);
      #1;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
   endtask

   task automatic wr(logic [31:0] a, logic [31:0] d);
      cycle(1'b1, a, d, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic rd(logic [31:0] a);
      cycle(1'b0, 32'd0, 32'd0, 1'b1, a, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic rdk(logic [31:0] a, logic [31:0] k);
      cycle(1'b0, 32'd0, 32'd0, 1'b1, a, 1'b0, 1'b1, k);
   endtask

   task automatic run_series(logic [31:0] x, logic [31:0] n);
      wr(A_OP, x);
      wr(A_TERMS, n);
      wr(A_CTRL, 32'd1);
   endtask

   // Monitor: compares the DUT read port against the queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (Device_Read_Data !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     e.name, Device_Read_Data, e.val, $time);
         end
      end
   end

   initial begin
      reset             = 1'b1;
      MemRead           = 1'b0;
      MemWrite          = 1'b0;
      MemBus_Address    = 32'd0;
      MemBus_Write_Data = 32'd0;
      model_reset();
      #2;
      reset = 1'b0;

      // Reset values
      cycle(1'b0, 32'd0, 32'd0, 1'b1, A_OP,     1'b1, 1'b1, 32'd0);
      cycle(1'b0, 32'd0, 32'd0, 1'b1, A_TERMS,  1'b1, 1'b1, 32'd5);
      cycle(1'b0, 32'd0, 32'd0, 1'b1, A_STATUS, 1'b1, 1'b1, 32'd0);
      cycle(1'b0, 32'd0, 32'd0, 1'b1, A_ANS,    1'b1, 1'b1, 32'd0);

      // x=2, N=5: busy for 5 cycles then 31
      run_series(32'd2, 32'd5);
      for (int i = 0; i < 5; i++) rdk(A_STATUS, 32'h1);
      rdk(A_ANS, 32'd31);
      rdk(A_STATUS, 32'h2);

      // Back-to-back runs leave no residue
      run_series(32'd3, 32'd5);
      for (int i = 0; i < 5; i++) rd(A_ANS);
      rdk(A_ANS, 32'd121);
      run_series(32'd7, 32'd3);
      for (int i = 0; i < 3; i++) rd(A_STATUS);
      rdk(A_ANS, 32'd57);

      // N=0 completes immediately; N=20 clamps to 16
      run_series(32'd7, 32'd0);
      rdk(A_STATUS, 32'h2);
      rdk(A_ANS, 32'd0);
      run_series(32'd1, 32'd20);
      for (int i = 0; i < 16; i++) rd(A_STATUS);
      rdk(A_ANS, 32'd16);
      rdk(A_TERMS, 32'd20);

      // Overflow, then cleared by the next start
      run_series(32'h0001_0000, 32'd3);
      for (int i = 0; i < 3; i++) rd(A_ANS);
      rdk(A_ANS, 32'h0001_0001);
      rdk(A_STATUS, 32'h6);
      run_series(32'd1, 32'd4);
      for (int i = 0; i < 4; i++) rd(A_ANS);
      rdk(A_ANS, 32'd4);
      rdk(A_STATUS, 32'h2);

      // Protected writes while busy, then abort
      run_series(32'd2, 32'd8);
      rd(A_ANS);
      rd(A_ANS);
      wr(A_OP, 32'd5);
      wr(A_CTRL, 32'd1);
      wr(A_CTRL, 32'd0);
      rdk(A_STATUS, 32'h0);
      rdk(A_ANS, 32'd15);
      rdk(A_OP, 32'd2);

      // Unmapped / read-only writes, and read-during-write of OP
      wr(A_ANS, 32'hDEAD_BEEF);
      wr(A_STATUS, 32'hFFFF_FFFF);
      wr(A_NONE, 32'h1234_5678);
      rdk(A_ANS, 32'd15);
      rd(A_NONE);
      rdk(A_CTRL, 32'd0);
      cycle(1'b1, A_OP, 32'd9, 1'b1, A_OP, 1'b0, 1'b1, 32'd2);
      rdk(A_OP, 32'd9);

      // Asynchronous reset mid-run
      run_series(32'd2, 32'd8);
      rd(A_ANS);
      rd(A_ANS);
      cycle(1'b0, 32'd0, 32'd0, 1'b1, A_ANS,    1'b1, 1'b1, 32'd0);
      cycle(1'b0, 32'd0, 32'd0, 1'b1, A_STATUS, 1'b1, 1'b1, 32'd0);
      cycle(1'b0, 32'd0, 32'd0, 1'b1, A_OP,     1'b1, 1'b1, 32'd0);
      cycle(1'b0, 32'd0, 32'd0, 1'b1, A_TERMS,  1'b1, 1'b1, 32'd5);
      wr(A_OP, 32'd9);
      cycle(1'b0, 32'd0, 32'd0, 1'b0, A_OP, 1'b0, 1'b1, 32'd0);
      rdk(A_OP, 32'd9);

      // Randomized runs with interference
      for (int it = 0; it < 40; it++) begin
         logic [31:0] x;
         logic [31:0] ra;
         int          sel;
         sel = $urandom_range(0, 3);
         case (sel)
            0:       x = 32'($urandom_range(0, 5));
            1:       x = 32'h0001_0000;
            2:       x = 32'hFFFF_FFFF;
            default: x = $urandom;
         endcase
         run_series(x, 32'($urandom_range(0, 20)));
         for (int c = 0; c < 25 && m_busy; c++) begin
            int          act;
            logic [31:0] wa;
            logic [31:0] wd;
            bit          we;
            act = $urandom_range(0, 9);
            we  = 1'b1;
            wa  = A_OP;
            wd  = $urandom;
            case (act)
               0:       begin wa = A_CTRL; wd = 32'd0; end
               1:       wa = A_OP;
               2:       begin wa = A_CTRL; wd = wd | 32'd1; end
               3:       wa = A_TERMS;
               default: we = 1'b0;
            endcase
            case ($urandom_range(0, 5))
               0:       ra = A_OP;
               1:       ra = A_ANS;
               2:       ra = A_CTRL;
               3:       ra = A_TERMS;
               4:       ra = A_STATUS;
               default: ra = A_NONE;
            endcase
            if (we) cycle(1'b1, wa, wd, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
            else    cycle(1'b0, 32'd0, 32'd0, $urandom_range(0, 3) != 0,
                          ra, 1'b0, 1'b0, 32'd0);
         end
         rd(A_STATUS);
         rd(A_ANS);
      end

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/poly_series_device.md
Name: poly_series_device

Overview:
- Memory-mapped accelerator on the MIPS pipeline data bus (MemBus) that evaluates the geometric series S = x^0 + x^1 + … + x^(N-1), modulo 2^DATA_W.
- Successor to the fixed 5-term device. Data width, base address and maximum term count are parameters.
- Adds a run-time term count, a status register (busy, done, overflow), abort, and a protected register file while busy.
- One term is accumulated per clock.

Parameters:
- DATA_W, 32: bus and datapath width.
- BASE_ADDR, 32'h40000000: byte address of register 0.
- MAX_TERMS, 16: upper clamp on N.
- CNT_W, 5: term counter width; must satisfy 2^CNT_W > MAX_TERMS.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- MemRead, input, 1: bus read strobe.
- MemWrite, input, 1: bus write strobe, sampled on the rising clk edge.
- MemBus_Address, input, 32: byte address.
- MemBus_Write_Data, input, DATA_W: write data.
- Device_Read_Data, output, DATA_W: read data, combinational.

Behaviour:
- Register map (offsets from BASE_ADDR):
  - 0x00 OP: read/write, x.
  - 0x04 ANS: read-only, accumulator.
  - 0x08 CTRL: write-only; any nonzero value = start, zero = abort.
  - 0x0C TERMS: read/write, low CNT_W+1 bits hold N.
  - 0x10 STATUS: read-only; bit0 busy, bit1 done, bit2 ovf, other bits 0.
- Reads:
  - Device_Read_Data = selected register when MemRead=1 and the address matches a readable register; otherwise 0.
  - Reading CTRL returns 0.
- Reset while reset=0, regardless of state: OP=0, TERMS=5, ANS=0, busy=0, done=0, ovf=0, state=IDLE.
- States:
  - IDLE: waiting for a start.
  - RUN: accumulating one term per clock.
- Start: a CTRL write with nonzero data while in IDLE. At that edge:
  - Capture n_eff = min(TERMS, MAX_TERMS).
  - acc=0, t=1, t_ovf=0, cnt=0, done=0, ovf=0.
  - If n_eff=0: stay IDLE and set done=1 (ANS=0).
  - Otherwise: go to RUN, busy=1.
- RUN edge (no abort):
  - acc <= acc + t.
  - t <= low DATA_W bits of t*x.
  - t_ovf <= t_ovf OR (high half of t*x nonzero).
  - ovf <= ovf OR t_ovf OR (carry out of acc+t).
  - cnt <= cnt+1.
  - When cnt+1 = n_eff: go to IDLE, busy=0, done=1.
- Latency: the result is valid and STATUS.done reads 1 exactly n_eff cycles after the start write edge. ANS shows partial sums while busy.
- Abort: a CTRL write with zero data while in RUN has priority over that edge's accumulate step.
  - Go to IDLE, busy=0, done=0.
  - ANS holds the last partial sum.
- Writes while busy:
  - Writes to OP and TERMS are ignored.
  - A nonzero CTRL write is ignored, with no restart.
- done and ovf are sticky until the next start or reset.
- Writes to ANS, STATUS and unmapped addresses have no effect.
- A simultaneous MemRead and MemWrite to the same register returns the pre-edge value.
- x is read live from OP. This is safe because OP is write-protected while busy.
- Address decode is an exact 32-bit compare against BASE_ADDR + offset.

Decomposition:
- Shared package poly_series_pkg holds:
  - Register offsets OFF_OP, OFF_ANS, OFF_CTRL, OFF_TERMS, OFF_STATUS.
  - Status bit indices ST_BUSY, ST_DONE, ST_OVF.
  - State enum {IDLE, RUN}.
  - TERMS reset value 5.
- One sub-module, series_term_unit: a combinational DATA_W×DATA_W multiply plus add with wrapped outputs and overflow flags, so the multiplier can later be pipelined in isolation.
- The top level holds the bus decode, registers and FSM.

Test Plan:
- OP=2, TERMS=5, CTRL=1 → busy=1 for 5 cycles; then ANS=31 (0x1F), STATUS=0x2.
- OP=3, TERMS=5 → ANS=121; then OP=7, TERMS=3, start → ANS=57 with no residue from the previous run.
- TERMS=0, start → next cycle STATUS=0x2, ANS=0, busy never set. TERMS=20 with OP=1 → clamped to 16, ANS=16.
- OP=0x00010000, TERMS=3 → ANS=0x00010001, STATUS=0x6 (ovf set). Then OP=1, TERMS=4 → ANS=4, ovf cleared.
- OP=2, TERMS=8, start; after 3 cycles write OP=5 and CTRL=1 → both ignored. At cycle 4 write CTRL=0 → IDLE, STATUS=0x0, ANS=15.
- Drive reset low mid-run (OP=2, TERMS=8) → immediately ANS=0, STATUS=0, OP=0, TERMS=5. After reset is released, reads with MemRead=0 return 0.
